// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler: accepts rpm command vectors, slew-limits each channel toward its
// target once per PWM period, and owns arm/disarm sequencing plus the command-loss watchdog.
module motor_cmd_scheduler #(
    parameter int NUM_MOTORS      = 4,
    parameter int RPM_W           = 7,
    parameter int PERIOD          = 2**RPM_W,
    parameter int SLEW_STEP       = 8,
    parameter int ARM_PERIODS     = 4,
    parameter int TIMEOUT_PERIODS = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [NUM_MOTORS*RPM_W-1:0] cmd_rpm,
    input  logic                        arm,
    input  logic                        disarm,
    output logic [NUM_MOTORS*RPM_W-1:0] mot_rpm,
    output logic                        set,
    output logic                        armed,
    output logic                        failsafe
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int ARM_W = $clog2(ARM_PERIODS + 1);
    localparam int WD_W  = $clog2(TIMEOUT_PERIODS + 1);
    localparam logic [RPM_W-1:0] STEP = RPM_W'(SLEW_STEP);

    typedef enum logic [1:0] {S_DISARMED, S_ARMING, S_ARMED, S_FAILSAFE} state_t;

    state_t                               r_state;
    logic [CNT_W-1:0]                     r_period_cnt;
    logic [ARM_W-1:0]                     r_arm_cnt;
    logic [WD_W-1:0]                      r_wd_cnt;
    logic [NUM_MOTORS-1:0][RPM_W-1:0]     r_target;
    logic [NUM_MOTORS-1:0][RPM_W-1:0]     r_applied;
    logic                                 r_set;
    logic                                 r_armed;
    logic                                 r_failsafe;

    logic                                 w_boundary;
    logic                                 w_xfer;
    logic                                 w_hold_zero;
    logic [NUM_MOTORS-1:0][RPM_W-1:0]     w_tgt;
    logic [NUM_MOTORS-1:0][RPM_W-1:0]     w_up;
    logic [NUM_MOTORS-1:0][RPM_W-1:0]     w_dn;
    logic [NUM_MOTORS-1:0][RPM_W-1:0]     w_slew;

    assign w_boundary  = (r_period_cnt == CNT_W'(PERIOD - 1));
    assign cmd_ready   = resetn & (r_state != S_FAILSAFE);
    assign w_xfer      = cmd_valid & cmd_ready;
    // A disarm on a boundary edge already zeroes the outputs on that edge.
    assign w_hold_zero = disarm | (r_state == S_DISARMED) | (r_state == S_ARMING);

    // Per-channel slew: step toward the target by at most STEP, never past it.
    for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_lane
        assign w_tgt[k]  = (r_state == S_FAILSAFE) ? '0 : r_target[k];
        assign w_up[k]   = w_tgt[k] - r_applied[k];
        assign w_dn[k]   = r_applied[k] - w_tgt[k];
        assign w_slew[k] = (w_tgt[k] > r_applied[k]) ? r_applied[k] + ((w_up[k] > STEP) ? STEP : w_up[k]) :
                           (w_tgt[k] < r_applied[k]) ? r_applied[k] - ((w_dn[k] > STEP) ? STEP : w_dn[k]) :
                           r_applied[k];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_DISARMED;
            r_period_cnt <= '0;
            r_arm_cnt    <= '0;
            r_wd_cnt     <= '0;
            r_target     <= '0;
            r_applied    <= '0;
            r_set        <= 1'b0;
            r_armed      <= 1'b0;
            r_failsafe   <= 1'b0;
        end else begin
            r_period_cnt <= w_boundary ? '0 : r_period_cnt + 1'b1;
            r_set        <= w_boundary;
            if (w_boundary)
                r_applied <= w_hold_zero ? '0 : w_slew;

            if (disarm) begin
                r_state <= S_DISARMED;
                r_armed <= 1'b0;
            end else begin
                case (r_state)
                    S_DISARMED: begin
                        if (arm) begin
                            r_state    <= S_ARMING;
                            r_arm_cnt  <= '0;
                            r_failsafe <= 1'b0;
                        end
                    end
                    S_ARMING: begin
                        if (w_boundary) begin
                            if (r_arm_cnt == ARM_W'(ARM_PERIODS - 1)) begin
                                r_state  <= S_ARMED;
                                r_armed  <= 1'b1;
                                r_target <= '0;
                                r_wd_cnt <= '0;
                            end else begin
                                r_arm_cnt <= r_arm_cnt + 1'b1;
                            end
                        end
                    end
                    S_ARMED: begin
                        // A transfer beats a coincident timeout boundary.
                        if (w_xfer) begin
                            r_target <= cmd_rpm;
                            r_wd_cnt <= '0;
                        end else if (w_boundary) begin
                            if (r_wd_cnt == WD_W'(TIMEOUT_PERIODS - 1)) begin
                                r_state    <= S_FAILSAFE;
                                r_armed    <= 1'b0;
                                r_failsafe <= 1'b1;
                                r_target   <= '0;
                            end else begin
                                r_wd_cnt <= r_wd_cnt + 1'b1;
                            end
                        end
                    end
                    S_FAILSAFE: begin
                        if (w_boundary && w_slew == '0)
                            r_state <= S_DISARMED;
                    end
                    default: r_state <= S_DISARMED;
                endcase
            end
        end
    end

    assign mot_rpm  = r_applied;
    assign set      = r_set;
    assign armed    = r_armed;
    assign failsafe = r_failsafe;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Bench for motor_cmd_scheduler: table of per-boundary slew steps, directed corner sequences,
// and randomized traffic compared every cycle against a boundary-level behavioural model.
module tb_motor_cmd_scheduler;
    localparam int NM      = 4;
    localparam int RW      = 7;
    localparam int PERIOD  = 128;
    localparam int SLEW    = 8;
    localparam int ARM_P   = 4;
    localparam int TMO_P   = 16;

    logic          clk;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [NM*RW-1:0] cmd_rpm;
    logic          arm;
    logic          disarm;
    logic [NM*RW-1:0] mot_rpm;
    logic          set;
    logic          armed;
    logic          failsafe;

    motor_cmd_scheduler dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rpm(cmd_rpm), .arm(arm), .disarm(disarm), .mot_rpm(mot_rpm),
        .set(set), .armed(armed), .failsafe(failsafe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NM*RW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {RW'(d), RW'(c), RW'(b), RW'(a)};
    endfunction

    // ---------------- behavioural model ----------------
    localparam int MD_DIS = 0, MD_ARMING = 1, MD_ARMED = 2, MD_FS = 3;
    int m_cnt, m_mode, m_since, m_set, m_fs;
    int m_app[NM];
    int m_tgt[NM];

    function automatic int slew(input int a, input int t);
        if (t > a) return a + ((t - a < SLEW) ? t - a : SLEW);
        if (t < a) return a - ((a - t < SLEW) ? a - t : SLEW);
        return a;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_mode = MD_DIS; m_since = 0; m_set = 0; m_fs = 0;
        for (int k = 0; k < NM; k++) begin m_app[k] = 0; m_tgt[k] = 0; end
    endtask

    task automatic model_step();
        bit bnd;
        bit xfer;
        bit allz;
        int na[NM];
        bnd  = (m_cnt == PERIOD - 1);
        xfer = cmd_valid && (m_mode != MD_FS);
        allz = 1;
        for (int k = 0; k < NM; k++) begin
            na[k] = m_app[k];
            if (bnd) begin
                if (disarm || m_mode == MD_DIS || m_mode == MD_ARMING) na[k] = 0;
                else na[k] = slew(m_app[k], (m_mode == MD_FS) ? 0 : m_tgt[k]);
            end
            if (na[k] != 0) allz = 0;
        end
        m_set = bnd;
        m_cnt = (m_cnt + 1) % PERIOD;
        if (disarm) m_mode = MD_DIS;
        else if (m_mode == MD_DIS) begin
            if (arm) begin m_mode = MD_ARMING; m_since = 0; m_fs = 0; end
        end else if (m_mode == MD_ARMING) begin
            if (bnd) m_since++;
            if (m_since == ARM_P) begin
                m_mode = MD_ARMED; m_since = 0;
                for (int k = 0; k < NM; k++) m_tgt[k] = 0;
            end
        end else if (m_mode == MD_ARMED) begin
            if (xfer) begin
                m_since = 0;
                for (int k = 0; k < NM; k++) m_tgt[k] = int'(cmd_rpm[k*RW +: RW]);
            end else if (bnd) begin
                m_since++;
                if (m_since == TMO_P) begin m_mode = MD_FS; m_fs = 1; end
            end
        end else if (bnd && allz) m_mode = MD_DIS;
        for (int k = 0; k < NM; k++) m_app[k] = na[k];
    endtask

    function automatic logic [31:0] model_out();
        logic [NM*RW-1:0] mv;
        for (int k = 0; k < NM; k++) mv[k*RW +: RW] = RW'(m_app[k]);
        return {mv, m_set[0], (m_mode == MD_ARMED), m_fs[0], (resetn && m_mode != MD_FS)};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) check("model", {mot_rpm, set, armed, failsafe, cmd_ready}, model_out());
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_set(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!set && n < 2*PERIOD + 10);
        if (!set) begin
            n_vec++; n_err++;
            $display("FAIL set_timeout: no set pulse within %0d cycles", n);
        end
    endtask

    task automatic send(input logic [NM*RW-1:0] v);
        cmd_rpm = v; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic reset_and_arm();
        int n;
        wait_set(n);
        check("first_set_latency", n, PERIOD);
        check("mot_after_reset", mot_rpm, 0);
        wait_set(n);
        check("set_period", n, PERIOD);
        arm = 1; @(posedge clk); #1; arm = 0;
        for (int b = 1; b <= ARM_P; b++) begin
            wait_set(n);
            check($sformatf("armed_at_bnd%0d", b), armed, (b == ARM_P));
            check("mot_zero_arming", mot_rpm, 0);
        end
    endtask

    typedef struct packed {
        logic             has_cmd;
        logic [NM*RW-1:0] cmd;
        logic [NM*RW-1:0] exp;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int n;
        clk = 0; resetn = 0; cmd_valid = 0; cmd_rpm = '0; arm = 0; disarm = 0;
        tbl[0] = '{1'b1, pack4(100, 5, 0, 127), pack4(8, 5, 0, 8)};
        tbl[1] = '{1'b0, pack4(0, 0, 0, 0),     pack4(16, 5, 0, 16)};
        tbl[2] = '{1'b1, pack4(20, 5, 3, 127),  pack4(20, 5, 3, 24)};
        tbl[3] = '{1'b1, pack4(0, 127, 3, 10),  pack4(12, 13, 3, 16)};
        tbl[4] = '{1'b0, pack4(0, 0, 0, 0),     pack4(4, 21, 3, 10)};
        tbl[5] = '{1'b0, pack4(0, 0, 0, 0),     pack4(0, 29, 3, 10)};
        tbl[6] = '{1'b1, pack4(9, 29, 11, 2),   pack4(8, 29, 11, 2)};
        tbl[7] = '{1'b0, pack4(0, 0, 0, 0),     pack4(9, 29, 11, 2)};

        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        check("reset_outputs", {mot_rpm, set, armed, failsafe, cmd_ready}, 0);
        resetn = 1;
        reset_and_arm();

        // Slew steps from the table, one boundary per record
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].has_cmd) begin idle(10); send(tbl[i].cmd); end
            wait_set(n);
            check($sformatf("table%0d", i), mot_rpm, tbl[i].exp);
        end

        // Command accepted on the boundary edge applies one period later
        idle(PERIOD - 1);
        send(pack4(50, 50, 50, 50));
        check("bnd_edge_set", set, 1);
        check("bnd_edge_not_applied", mot_rpm, pack4(9, 29, 11, 2));
        wait_set(n);
        check("bnd_edge_next", mot_rpm, pack4(17, 37, 19, 10));

        // Two commands within one period: only the second lands
        idle(5);  send(pack4(0, 0, 0, 0));
        idle(20); send(pack4(60, 60, 60, 60));
        wait_set(n);
        check("second_cmd_wins", mot_rpm, pack4(25, 45, 27, 18));

        // Watchdog timeout and failsafe ramp-down
        idle(10); send(pack4(40, 40, 40, 40));
        for (int b = 1; b <= TMO_P; b++) begin
            wait_set(n);
            if (b >= 3) check("wd_hold_40", mot_rpm, pack4(40, 40, 40, 40));
            check($sformatf("failsafe_bnd%0d", b), failsafe, (b == TMO_P));
            check($sformatf("ready_bnd%0d", b), cmd_ready, (b != TMO_P));
        end
        idle(30); send(pack4(127, 127, 127, 127));
        for (int i = 0; i < 5; i++) begin
            wait_set(n);
            check($sformatf("fs_ramp%0d", i), mot_rpm, pack4(32 - 8*i, 32 - 8*i, 32 - 8*i, 32 - 8*i));
        end
        check("fs_done_armed", armed, 0);
        check("fs_done_failsafe", failsafe, 1);
        check("fs_done_ready", cmd_ready, 1);

        // Re-arm clears failsafe, ramp to 100, then disarm with arm held
        arm = 1; @(posedge clk); #1; arm = 0;
        check("failsafe_clear", failsafe, 0);
        for (int b = 1; b <= ARM_P; b++) begin
            wait_set(n);
            check("rearm", armed, (b == ARM_P));
        end
        idle(10); send(pack4(100, 100, 100, 100));
        for (int b = 1; b <= 13; b++) begin
            wait_set(n);
            check($sformatf("ramp100_b%0d", b), mot_rpm,
                  pack4((8*b < 100) ? 8*b : 100, (8*b < 100) ? 8*b : 100,
                        (8*b < 100) ? 8*b : 100, (8*b < 100) ? 8*b : 100));
        end
        idle(20);
        arm = 1; disarm = 1;
        @(posedge clk); #1;
        check("disarm_armed_drop", armed, 0);
        check("disarm_mot_hold", mot_rpm, pack4(100, 100, 100, 100));
        wait_set(n);
        check("disarm_mot_zero", mot_rpm, 0);
        check("disarm_over_arm", armed, 0);
        disarm = 0;
        for (int b = 1; b <= ARM_P; b++) begin
            wait_set(n);
            check("arm_after_disarm", armed, (b == ARM_P));
        end
        arm = 0;

        // Asynchronous reset mid-ramp, landing between clock edges while set is high
        idle(10); send(pack4(100, 100, 100, 100));
        repeat (3) wait_set(n);
        check("ramp24", mot_rpm, pack4(24, 24, 24, 24));
        #2 resetn = 0;
        #1 check("async_reset", {mot_rpm, set, armed, cmd_ready}, 0);
        repeat (3) @(negedge clk);
        resetn = 1;
        reset_and_arm();

        // Randomized traffic; every third segment starves the watchdog
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 2500; c++) begin
                cmd_valid = (seg % 3 != 0) && ($urandom_range(0, 63) == 0);
                cmd_rpm   = (NM*RW)'($urandom);
                arm       = ($urandom_range(0, 99) == 0);
                disarm    = ($urandom_range(0, 3999) == 0);
                @(posedge clk); #1;
            end
        end
        cmd_valid = 0; arm = 0; disarm = 0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
